tiny_ctrl: RTL and testbench
============================

TINY_CTRL -- requirements
Module: tiny_ctrl

Interface
REQ-001 Parameter IMEM_AW, default 8, instruction address width (pc width).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 run  input  1  sequencer enable, sampled only in FETCH.
REQ-005 pc  output  IMEM_AW  instruction address to external ROM.
REQ-006 instr  input  16  ROM data, valid combinationally for current pc: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-007 alu_a, alu_b  output  8  ALU operands: alu_a = R[rd], alu_b = R[rs] of latched instruction.
REQ-008 alu_op  output  4  ALU function: 4'h0 add, 4'h1 sub.
REQ-009 alu_e  input  8  ALU result.
REQ-010 alu_cc  input  2  ALU compare code: [1] A==B, [0] A>B.
REQ-011 out_port  output  8  last value written by OUT.
REQ-012 out_valid  output  1  one-cycle pulse when out_port updates.
REQ-013 halted  output  1  high while in HALT state.

Function
REQ-014 FSM states FETCH, EXEC, HALT; every non-halting instruction takes exactly 2 cycles.
REQ-015 FETCH: if run=1, latch instr into ir, go EXEC; if run=0, hold state, pc and ir.
REQ-016 EXEC: execute ir per REQ-017..REQ-024, go FETCH (HALT for opcode 8).
REQ-017 Opcode 0 ADD: alu_op=4'h0, R[rd] <= alu_e; pc <= pc+1.
REQ-018 Opcode 1 SUB: alu_op=4'h1, R[rd] <= alu_e; pc <= pc+1.
REQ-019 Opcode 2 LDI: R[rd] <= imm; pc <= pc+1.
REQ-020 Opcode 3 CMP: flags <= alu_cc; no register write; pc <= pc+1.
REQ-021 Opcode 4 JMP: pc <= imm; opcode 5 JEQ: pc <= imm if flags[1] else pc+1; opcode 6 JGT: pc <= imm if flags[0] else pc+1.
REQ-022 Opcode 7 OUT: out_port <= R[rd], out_valid=1 for that one cycle; pc <= pc+1.
REQ-023 Opcode 8 HALT: enter HALT, pc unchanged; HALT exits only via rst; run ignored.
REQ-024 Opcodes 9..15: NOP, pc <= pc+1 (see REQ-029 for 9).
REQ-025 alu_op = 4'h0 in every state/opcode except SUB and CMP in EXEC (4'h1).
REQ-026 pc arithmetic modulo 2^IMEM_AW: all-ones + 1 wraps to 0; imm zero-extended or truncated to IMEM_AW.
REQ-027 ADD/SUB results wrap modulo 256; no carry flag; flags change only on CMP.

Reset
REQ-028 On rst=1 at a clock edge, regardless of state: state=FETCH, pc=0, ir=0, R0..R3=0, flags=2'b00, out_port=0, out_valid=0, halted=0; any in-flight instruction is discarded without side effects.

Configuration
REQ-029 Macro TINY_CTRL_JLT_EN defined: opcode 9 is JLT, pc <= imm if flags==2'b00 else pc+1; undefined: opcode 9 is NOP per REQ-024.

Structure
REQ-030 Package tiny_cpu_pkg holds opcode constants, ALU op codes (ADD 4'h0, SUB 4'h1), FSM state enum, instruction field positions.
REQ-031 One sub-module, tiny_ctrl_regfile: 4x8 registers, two combinational read ports, one synchronous write port, reset to 0.

Verification
REQ-032 LDI R0,5; LDI R1,3; ADD R0,R1; OUT R0 -> out_port=8, single out_valid pulse, pc=4 after 8 cycles.
REQ-033 LDI R0,7; LDI R1,7; CMP R0,R1; JEQ 0x20 -> pc=0x20; repeat with R1=9 -> pc=4; CMP R1>R0 with JGT -> taken.
REQ-034 LDI R0,0; LDI R1,1; SUB R0,R1 -> R0=0xFF; JMP 0xFF then NOP at 0xFF -> pc wraps to 0x00.
REQ-035 run=0 for 5 cycles in FETCH -> pc, regs, outputs frozen; run=1 resumes with no skipped instruction.
REQ-036 HALT -> halted=1, pc constant for 20 cycles with run=1; rst asserted in EXEC of an OUT -> no out_valid, all outputs per REQ-028.
REQ-037 Opcode 9 with flags=00: taken when TINY_CTRL_JLT_EN defined, pc+1 otherwise.

Source files
------------

// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny_ctrl sequencer: opcodes, ALU codes, FSM states, instruction layout.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Optional feature macro consumed by users of this package: TINY_CTRL_JLT_EN (opcode 9 becomes JLT).
package tiny_cpu_pkg;

    // Opcodes, instr[15:12]
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_CMP  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JEQ  = 4'h5;
    localparam logic [3:0] OP_JGT  = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'h8;
    localparam logic [3:0] OP_JLT  = 4'h9;

    // ALU function codes driven on alu_op
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    // Instruction field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Packed view of an instruction; member order matches the field positions above.
    typedef struct packed {
        logic [OPC_MSB:OPC_LSB] opc;
        logic [RD_MSB-RD_LSB:0] rd;
        logic [RS_MSB-RS_LSB:0] rs;
        logic [IMM_MSB:IMM_LSB] imm;
    } instr_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // SUB and CMP both need a subtracting ALU; everything else sees ADD.
    function automatic logic [3:0] alu_op_for(input logic [3:0] opc);
        return ((opc == OP_SUB) || (opc == OP_CMP)) ? ALU_SUB : ALU_ADD;
    endfunction

endpackage

// File: rtl/tiny_ctrl_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
// Latency: reads same cycle, writes visible the cycle after the write edge.
// Backpressure: none; a write is accepted every cycle we is high.
//
// Ports: clk/rst (sync, active-high, clears all registers), ra_addr/ra_data and
// rb_addr/rb_data (read ports), we/wa/wd (write port).
module tiny_ctrl_regfile (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ra_addr,
    output logic [7:0] ra_data,
    input  logic [1:0] rb_addr,
    output logic [7:0] rb_data,
    input  logic       we,
    input  logic [1:0] wa,
    input  logic [7:0] wd
);

    logic [7:0] regs [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/tiny_ctrl.sv
// Two-cycle FETCH/EXEC instruction sequencer driving an external ROM and ALU.
// Latency: each non-halting instruction takes exactly 2 cycles; out_port/out_valid update the cycle after OUT executes.
// Backpressure: run=0 while in FETCH stalls the sequencer with all state frozen; HALT is left only through rst.
//
// Ports: clk, rst (sync, active-high); run (enable, sampled in FETCH); pc -> ROM address, instr <- ROM data;
// alu_a/alu_b/alu_op -> external ALU, alu_e/alu_cc <- result and compare code {A==B, A>B};
// out_port/out_valid (OUT result + one-cycle strobe); halted.
// Build option: define TINY_CTRL_JLT_EN to make opcode 9 a JLT (taken when flags==00) instead of a NOP.
module tiny_ctrl
    import tiny_cpu_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [IMEM_AW-1:0] pc,
    input  logic [15:0]        instr,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [3:0]         alu_op,
    input  logic [7:0]         alu_e,
    input  logic [1:0]         alu_cc,
    output logic [7:0]         out_port,
    output logic               out_valid,
    output logic               halted
);

    localparam logic [IMEM_AW-1:0] PC_ONE = 1;

    state_t             state;
    instr_t             ir;
    logic [1:0]         flags;
    logic [IMEM_AW-1:0] pc_inc;
    logic [IMEM_AW-1:0] imm_pc;
    logic               rf_we;
    logic [7:0]         rf_wd;

    // Jump targets: the 8-bit immediate is zero-extended or truncated to the pc width.
    generate
        if (IMEM_AW == 8) begin : g_imm_eq
            assign imm_pc = ir.imm;
        end else if (IMEM_AW > 8) begin : g_imm_ext
            assign imm_pc = {{(IMEM_AW-8){1'b0}}, ir.imm};
        end else begin : g_imm_trunc
            assign imm_pc = ir.imm[IMEM_AW-1:0];
        end
    endgenerate

    // Wraps naturally at all-ones.
    assign pc_inc = pc + PC_ONE;

    // Register writeback only happens in EXEC, so reset in EXEC discards it cleanly.
    assign rf_we = (state == ST_EXEC) &&
                   ((ir.opc == OP_ADD) || (ir.opc == OP_SUB) || (ir.opc == OP_LDI));
    assign rf_wd = (ir.opc == OP_LDI) ? ir.imm : alu_e;

    tiny_ctrl_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (ir.rd),
        .ra_data (alu_a),
        .rb_addr (ir.rs),
        .rb_data (alu_b),
        .we      (rf_we),
        .wa      (ir.rd),
        .wd      (rf_wd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= '0;
            ir        <= '0;
            flags     <= 2'b00;
            out_port  <= 8'h00;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            alu_op    <= ALU_ADD;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (run) begin
                        ir     <= instr;
                        // alu_op is registered alongside ir so it is valid for the whole EXEC cycle.
                        alu_op <= alu_op_for(instr[OPC_MSB:OPC_LSB]);
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_op <= ALU_ADD;
                    state  <= ST_FETCH;
                    pc     <= pc_inc;
                    case (ir.opc)
                        OP_CMP: flags <= alu_cc;
                        OP_JMP: pc <= imm_pc;
                        OP_JEQ: if (flags[1]) pc <= imm_pc;
                        OP_JGT: if (flags[0]) pc <= imm_pc;
                        OP_OUT: begin
                            out_port  <= alu_a;
                            out_valid <= 1'b1;
                        end
                        OP_HALT: begin
                            pc     <= pc;
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
`ifdef TINY_CTRL_JLT_EN
                        OP_JLT: if (flags == 2'b00) pc <= imm_pc;
`endif
                        default: ;
                    endcase
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_ctrl.sv
// Self-checking bench for tiny_ctrl: table of short programs plus hand-written corner sequences.
// Latency: n/a.  Backpressure: n/a.
module tb_tiny_ctrl;

    localparam logic [3:0] T_ADD = 4'h0, T_SUB = 4'h1, T_LDI = 4'h2, T_CMP = 4'h3,
                           T_JMP = 4'h4, T_JEQ = 4'h5, T_JGT = 4'h6, T_OUT = 4'h7,
                           T_HLT = 4'h8, T_OP9 = 4'h9;
    localparam logic [15:0] NOP = 16'hF000;
`ifdef TINY_CTRL_JLT_EN
    localparam logic [7:0] JLT_PC = 8'h40;
`else
    localparam logic [7:0] JLT_PC = 8'h04;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] pc;
    logic [15:0] instr;
    logic [7:0] alu_a, alu_b, alu_e, out_port;
    logic [3:0] alu_op;
    logic [1:0] alu_cc;
    logic       out_valid, halted;

    logic [15:0] rom [256];
    logic [7:0]  exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // External ROM and ALU models
    assign instr  = rom[pc];
    assign alu_e  = (alu_op == 4'h1) ? (alu_a - alu_b) : (alu_a + alu_b);
    assign alu_cc = {alu_a == alu_b, alu_a > alu_b};

    tiny_ctrl #(.IMEM_AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .pc        (pc),
        .instr     (instr),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_e     (alu_e),
        .alu_cc    (alu_cc),
        .out_port  (out_port),
        .out_valid (out_valid),
        .halted    (halted)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse pops one expected out_port value.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_extra: got out_valid with out_port %0h expected no pulse", out_port);
            end else begin
                chk("out_port", {24'h0, out_port}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    typedef struct {
        string             name;
        int                cycles;
        logic [7:0]        exp_pc;
        logic              exp_halt;
        int                n_out;
        logic [7:0]        out0;
        logic [7:0]        out1;
        logic [5:0][15:0]  p;
    } vec_t;

    vec_t vecs [$];

    function automatic void add(input string nm, input int cyc, input logic [7:0] epc,
                                input logic eh, input int no, input logic [7:0] o0,
                                input logic [7:0] o1, input logic [15:0] i0, input logic [15:0] i1,
                                input logic [15:0] i2, input logic [15:0] i3,
                                input logic [15:0] i4, input logic [15:0] i5);
        vec_t v;
        v.name = nm; v.cycles = cyc; v.exp_pc = epc; v.exp_halt = eh;
        v.n_out = no; v.out0 = o0; v.out1 = o1;
        v.p[0] = i0; v.p[1] = i1; v.p[2] = i2; v.p[3] = i3; v.p[4] = i4; v.p[5] = i5;
        vecs.push_back(v);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic load(input logic [5:0][15:0] p);
        for (int a = 0; a < 256; a++) rom[a] = NOP;
        for (int k = 0; k < 6; k++) rom[k] = p[k];
    endtask

    initial begin
        logic [5:0][15:0] prog;

        add("add_out", 8, 8'h04, 1'b0, 1, 8'h08, 8'h00,
            enc(T_LDI,0,0,8'd5), enc(T_LDI,1,0,8'd3), enc(T_ADD,0,1,0), enc(T_OUT,0,0,0), NOP, NOP);
        add("jeq_taken", 8, 8'h20, 1'b0, 0, 8'h00, 8'h00,
            enc(T_LDI,0,0,8'd7), enc(T_LDI,1,0,8'd7), enc(T_CMP,0,1,0), enc(T_JEQ,0,0,8'h20), NOP, NOP);
        add("jeq_not", 8, 8'h04, 1'b0, 0, 8'h00, 8'h00,
            enc(T_LDI,0,0,8'd7), enc(T_LDI,1,0,8'd9), enc(T_CMP,0,1,0), enc(T_JEQ,0,0,8'h20), NOP, NOP);
        add("jgt_taken", 8, 8'h30, 1'b0, 0, 8'h00, 8'h00,
            enc(T_LDI,0,0,8'd3), enc(T_LDI,1,0,8'd9), enc(T_CMP,1,0,0), enc(T_JGT,0,0,8'h30), NOP, NOP);
        add("jgt_not_eq", 8, 8'h04, 1'b0, 0, 8'h00, 8'h00,
            enc(T_LDI,0,0,8'd5), enc(T_LDI,1,0,8'd5), enc(T_CMP,0,1,0), enc(T_JGT,0,0,8'h30), NOP, NOP);
        add("sub_wrap", 12, 8'h00, 1'b0, 1, 8'hFF, 8'h00,
            enc(T_LDI,0,0,8'd0), enc(T_LDI,1,0,8'd1), enc(T_SUB,0,1,0), enc(T_OUT,0,0,0),
            enc(T_JMP,0,0,8'hFF), NOP);
        add("add_wrap", 8, 8'h04, 1'b0, 1, 8'h10, 8'h00,
            enc(T_LDI,0,0,8'hF0), enc(T_LDI,1,0,8'h20), enc(T_ADD,0,1,0), enc(T_OUT,0,0,0), NOP, NOP);
        add("flags_hold", 12, 8'h50, 1'b0, 1, 8'h04, 8'h00,
            enc(T_LDI,0,0,8'd4), enc(T_LDI,1,0,8'd4), enc(T_CMP,0,1,0), enc(T_ADD,2,0,0),
            enc(T_OUT,2,0,0), enc(T_JEQ,0,0,8'h50));
        add("nop_ops", 8, 8'h04, 1'b0, 1, 8'h77, 8'h00,
            enc(T_LDI,3,0,8'h77), enc(4'hC,0,0,8'h10), enc(4'hA,3,3,8'h99), enc(T_OUT,3,0,0), NOP, NOP);
        add("halt", 26, 8'h02, 1'b1, 1, 8'h42, 8'h00,
            enc(T_LDI,2,0,8'h42), enc(T_OUT,2,0,0), enc(T_HLT,0,0,8'h10), NOP, NOP, NOP);
        add("op9_flags00", 8, JLT_PC, 1'b0, 0, 8'h00, 8'h00,
            enc(T_LDI,0,0,8'd1), enc(T_LDI,1,0,8'd5), enc(T_CMP,0,1,0), enc(T_OP9,0,0,8'h40), NOP, NOP);
        add("op9_flags_gt", 8, 8'h04, 1'b0, 0, 8'h00, 8'h00,
            enc(T_LDI,0,0,8'd6), enc(T_LDI,1,0,8'd5), enc(T_CMP,0,1,0), enc(T_OP9,0,0,8'h40), NOP, NOP);
        add("two_outs", 8, 8'h04, 1'b0, 2, 8'h11, 8'h22,
            enc(T_LDI,0,0,8'h11), enc(T_OUT,0,0,0), enc(T_LDI,0,0,8'h22), enc(T_OUT,0,0,0), NOP, NOP);

        for (int a = 0; a < 256; a++) rom[a] = NOP;

        // Reset state
        do_reset();
        chk("rst_pc", {24'h0, pc}, 32'h0);
        chk("rst_out_port", {24'h0, out_port}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_alu_op", {28'h0, alu_op}, 32'h0);
        chk("rst_alu_a", {24'h0, alu_a}, 32'h0);

        // Program table
        for (int t = 0; t < vecs.size(); t++) begin
            rst = 1'b1;
            run = 1'b0;
            load(vecs[t].p);
            tick(2);
            rst = 1'b0;
            if (vecs[t].n_out > 0) exp_q.push_back(vecs[t].out0);
            if (vecs[t].n_out > 1) exp_q.push_back(vecs[t].out1);
            run = 1'b1;
            tick(vecs[t].cycles);
            chk({vecs[t].name, "_pc"}, {24'h0, pc}, {24'h0, vecs[t].exp_pc});
            chk({vecs[t].name, "_halted"}, {31'h0, halted}, {31'h0, vecs[t].exp_halt});
            run = 1'b0;
            tick(2);
            chk({vecs[t].name, "_outs_left"}, exp_q.size(), 0);
            exp_q.delete();
        end

        // alu_op/operands during EXEC of SUB, then back to ADD code in FETCH
        prog = '0;
        prog[0] = enc(T_LDI,0,0,8'd9); prog[1] = enc(T_LDI,1,0,8'd4); prog[2] = enc(T_SUB,0,1,0);
        prog[3] = NOP; prog[4] = NOP; prog[5] = NOP;
        load(prog);
        do_reset();
        run = 1'b1;
        tick(5);
        chk("sub_alu_op", {28'h0, alu_op}, 32'h1);
        chk("sub_alu_a", {24'h0, alu_a}, 32'h9);
        chk("sub_alu_b", {24'h0, alu_b}, 32'h4);
        tick(1);
        chk("fetch_alu_op", {28'h0, alu_op}, 32'h0);
        chk("sub_result", {24'h0, alu_a}, 32'h5);

        // run=0 freeze in FETCH, then resume without skipping
        prog[0] = enc(T_LDI,0,0,8'd5); prog[1] = enc(T_LDI,1,0,8'd6); prog[2] = enc(T_OUT,1,0,0);
        load(prog);
        do_reset();
        exp_q.push_back(8'h06);
        run = 1'b1;
        tick(2);
        run = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            chk("freeze_pc", {24'h0, pc}, 32'h1);
            chk("freeze_alu_a", {24'h0, alu_a}, 32'h5);
            chk("freeze_out_valid", {31'h0, out_valid}, 32'h0);
        end
        run = 1'b1;
        tick(4);
        chk("resume_pc", {24'h0, pc}, 32'h3);
        run = 1'b0;
        tick(2);
        chk("resume_outs_left", exp_q.size(), 0);
        exp_q.delete();

        // HALT holds pc with run=1, and rst leaves HALT
        prog[0] = enc(T_LDI,2,0,8'h42); prog[1] = enc(T_OUT,2,0,0); prog[2] = enc(T_HLT,0,0,8'h10);
        load(prog);
        do_reset();
        exp_q.push_back(8'h42);
        run = 1'b1;
        tick(6);
        chk("halt_entered", {31'h0, halted}, 32'h1);
        for (int c = 0; c < 20; c++) begin
            tick(1);
            chk("halt_pc", {24'h0, pc}, 32'h2);
        end
        chk("halt_still", {31'h0, halted}, 32'h1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        run = 1'b0;
        chk("halt_rst_halted", {31'h0, halted}, 32'h0);
        chk("halt_rst_pc", {24'h0, pc}, 32'h0);
        chk("halt_outs_left", exp_q.size(), 0);
        exp_q.delete();

        // rst during EXEC of OUT: pulse and register contents discarded
        prog[0] = enc(T_LDI,0,0,8'd9); prog[1] = enc(T_OUT,0,0,0); prog[2] = NOP;
        load(prog);
        do_reset();
        run = 1'b1;
        tick(3);
        chk("pre_rst_alu_a", {24'h0, alu_a}, 32'h9);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_out_port", {24'h0, out_port}, 32'h0);
        chk("mid_rst_pc", {24'h0, pc}, 32'h0);
        chk("mid_rst_halted", {31'h0, halted}, 32'h0);
        chk("mid_rst_alu_a", {24'h0, alu_a}, 32'h0);
        chk("mid_rst_alu_op", {28'h0, alu_op}, 32'h0);
        rst = 1'b0;
        run = 1'b0;
        tick(3);
        chk("post_rst_out_port", {24'h0, out_port}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
